// File: rtl/robot_key_encoder_if.sv
// Key byte stream, robot alive flag and movement outputs of robot_key_encoder.
// master drives key bytes and show_valid; slave is the encoder itself.
interface robot_key_encoder_if;
  logic       key_valid;
  logic [7:0] key_data;
  logic       show_valid;
  logic [3:0] move_opr;
  logic       key_any;

  modport master (
    output key_valid,
    output key_data,
    output show_valid,
    input  move_opr,
    input  key_any
  );

  modport slave (
    input  key_valid,
    input  key_data,
    input  show_valid,
    output move_opr,
    output key_any
  );
endinterface

// File: rtl/robot_key_encoder.sv
// PS/2 set-2 scan-code parser tracking WASD and arrow keys, producing a registered
// {up,down,left,right} robot command with idle timeout that releases all held keys.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | waiting for first byte of a sequence
// ST_EXT     | E0 seen, next byte is an extended make (or F0)
// ST_BRK     | F0 seen, next byte is a plain break
// ST_EXT_BRK | E0 F0 seen, next byte is an extended break
module robot_key_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input logic               clk,
  input logic               rst,
  robot_key_encoder_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam int unsigned K_W     = 0;
  localparam int unsigned K_S     = 1;
  localparam int unsigned K_A     = 2;
  localparam int unsigned K_D     = 3;
  localparam int unsigned K_UP    = 4;
  localparam int unsigned K_DOWN  = 5;
  localparam int unsigned K_LEFT  = 6;
  localparam int unsigned K_RIGHT = 7;

  localparam logic [7:0] C_EXT = 8'hE0;
  localparam logic [7:0] C_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_flags;
  logic [7:0]    w_set;
  logic [7:0]    w_clr;
  logic [CW-1:0] r_idle_cnt;
  logic          w_timeout;
  logic [3:0]    w_move;
  logic [3:0]    r_move_opr;
  logic          r_key_any;

  function automatic logic [7:0] decode_plain(input logic [7:0] code);
    logic [7:0] mask;
    mask = '0;
    case (code)
      8'h1D:   mask[K_W] = 1'b1;
      8'h1B:   mask[K_S] = 1'b1;
      8'h1C:   mask[K_A] = 1'b1;
      8'h23:   mask[K_D] = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic [7:0] decode_ext(input logic [7:0] code);
    logic [7:0] mask;
    mask = '0;
    case (code)
      8'h75:   mask[K_UP]    = 1'b1;
      8'h72:   mask[K_DOWN]  = 1'b1;
      8'h6B:   mask[K_LEFT]  = 1'b1;
      8'h74:   mask[K_RIGHT] = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

  // Timeout only matters on cycles without a byte; a byte always wins.
  assign w_timeout = (r_idle_cnt == TO_LAST) && !bus.key_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_set        = '0;
    w_clr        = '0;
    if (bus.key_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_data == C_EXT) begin
            w_state_next = ST_EXT;
          end else if (bus.key_data == C_BRK) begin
            w_state_next = ST_BRK;
          end else begin
            w_set = decode_plain(bus.key_data);
          end
        end
        ST_EXT: begin
          if (bus.key_data == C_BRK) begin
            w_state_next = ST_EXT_BRK;
          end else if (bus.key_data == C_EXT) begin
            w_state_next = ST_EXT;
          end else begin
            w_set        = decode_ext(bus.key_data);
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_clr        = decode_plain(bus.key_data);
          w_state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_clr        = decode_ext(bus.key_data);
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (bus.key_valid) begin
      r_flags <= (r_flags | w_set) & ~w_clr;
    end else if (w_timeout) begin
      r_flags <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (bus.key_valid) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != TO_MAX) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Opposing directions are deliberately not arbitrated here; the motion block decides.
  assign w_move = {r_flags[K_W] | r_flags[K_UP],
                   r_flags[K_S] | r_flags[K_DOWN],
                   r_flags[K_A] | r_flags[K_LEFT],
                   r_flags[K_D] | r_flags[K_RIGHT]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_move_opr <= 4'b0000;
      r_key_any  <= 1'b0;
    end else begin
      r_move_opr <= bus.show_valid ? w_move : 4'b0000;
      r_key_any  <= |r_flags;
    end
  end

  assign bus.move_opr = r_move_opr;
  assign bus.key_any  = r_key_any;

endmodule

// File: tb/tb_robot_key_encoder.sv
// Directed bench for robot_key_encoder with a short timeout; expected values are
// hand-computed from the key sequences.
module tb_robot_key_encoder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  robot_key_encoder_if bus ();

  robot_key_encoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    bus.key_valid = 1'b1;
    bus.key_data  = b;
    tick();
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_data   = 8'h00;
    bus.show_valid = 1'b1;
    ticks(2);
    rst = 1'b0;
    check("rst_move", {4'b0, bus.move_opr}, 8'h00);
    check("rst_any", {7'b0, bus.key_any}, 8'h00);

    // W make then break
    send(8'h1D); tick();
    check("w_move", {4'b0, bus.move_opr}, 8'h08);
    check("w_any", {7'b0, bus.key_any}, 8'h01);
    send(8'hF0); send(8'h1D); tick();
    check("w_brk_move", {4'b0, bus.move_opr}, 8'h00);
    check("w_brk_any", {7'b0, bus.key_any}, 8'h00);

    // RIGHT (extended) plus A
    send(8'hE0); send(8'h74); send(8'h1C); tick();
    check("right_a", {4'b0, bus.move_opr}, 8'h03);
    send(8'hE0); send(8'hF0); send(8'h74); tick();
    check("right_brk", {4'b0, bus.move_opr}, 8'h02);
    send(8'hF0); send(8'h1C); tick();
    check("a_brk", {4'b0, bus.move_opr}, 8'h00);

    // robot dead masks motion but not key_any
    send(8'h1D); tick();
    bus.show_valid = 1'b0;
    tick();
    check("dead_move", {4'b0, bus.move_opr}, 8'h00);
    check("dead_any", {7'b0, bus.key_any}, 8'h01);
    bus.show_valid = 1'b1;
    tick();
    check("alive_move", {4'b0, bus.move_opr}, 8'h08);
    send(8'h1B); tick();
    check("opposing", {4'b0, bus.move_opr}, 8'h0C);
    send(8'hF0); send(8'h1B); send(8'hF0); send(8'h1D); tick();
    check("clear_ws", {4'b0, bus.move_opr}, 8'h00);

    // Timeout boundary: 15 idle edges keep the key, a byte at the 16th wins
    send(8'h23);
    ticks(15);
    check("to_hold15", {4'b0, bus.move_opr}, 8'h01);
    send(8'h23);
    ticks(15);
    check("to_rearm", {4'b0, bus.move_opr}, 8'h01);
    tick();
    check("to_edge_any", {7'b0, bus.key_any}, 8'h01);
    tick();
    check("to_clear_move", {4'b0, bus.move_opr}, 8'h00);
    check("to_clear_any", {7'b0, bus.key_any}, 8'h00);

    // Timeout also returns the parser to IDLE
    send(8'hE0);
    ticks(17);
    send(8'h75); tick();
    check("to_fsm_idle", {4'b0, bus.move_opr}, 8'h00);

    // Reset discards a half-received extended sequence
    send(8'hE0);
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h75); tick();
    check("rst_discard", {4'b0, bus.move_opr}, 8'h00);
    send(8'hF0); send(8'hF0); send(8'h1B); tick();
    check("f0f0_down", {4'b0, bus.move_opr}, 8'h04);
    check("f0f0_any", {7'b0, bus.key_any}, 8'h01);

    // Untracked bytes, typematic repeat, break of a key not held
    send(8'hAA); send(8'hE1); send(8'hFA); tick();
    check("untracked", {4'b0, bus.move_opr}, 8'h04);
    send(8'h1B); send(8'h1B); tick();
    check("typematic", {4'b0, bus.move_opr}, 8'h04);
    send(8'hF0); send(8'h1D); tick();
    check("brk_not_held", {4'b0, bus.move_opr}, 8'h04);
    send(8'hE0); send(8'h72); tick();
    check("down_both", {4'b0, bus.move_opr}, 8'h04);
    send(8'hF0); send(8'h1B); tick();
    check("down_ext_left", {4'b0, bus.move_opr}, 8'h04);

    // Reset beats a simultaneous key byte
    bus.key_valid = 1'b1;
    bus.key_data  = 8'h1D;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    tick();
    check("rst_prio_move", {4'b0, bus.move_opr}, 8'h00);
    check("rst_prio_any", {7'b0, bus.key_any}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
